hex_display_ctrl: RTL



---
 rtl/hex_display_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hex_display_ctrl.sv
// Multi-digit hexadecimal seven-segment display controller.
// Holds a 4*DIGITS-bit value written by a strobe and drives active-low
// segments, decimal points and digit enables. It supports leading-zero
// blanking, per-digit blinking, and either static or scanned output.
module hex_display_ctrl #(
  parameter int DIGITS     = 6,
  parameter int SCAN_MODE  = 0,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Active-low gfedcba glyph for one hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  logic [4*DIGITS-1:0] value;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [IDXW-1:0] scan_idx;
  logic [DIVW-1:0] scan_div;

  logic [6:0] dig_seg [DIGITS];
  logic       dig_dp  [DIGITS];
  logic [7*DIGITS-1:0] seg_next;
  logic [DIGITS-1:0]   dp_next;
  logic [DIGITS-1:0]   en_next;
  logic                seen_nz;
  logic                blink_on;

  // Per-digit glyphs with blanking and blinking, then static or scanned selection.
  always_comb begin
    seen_nz  = 1'b0;
    blink_on = blink_cnt[BLINK_BITS-1];
    seg_next = '1;
    dp_next  = '1;
    en_next  = '0;
    // Walk from the most significant digit down so seen_nz tells whether any
    // nibble at or above the current position is non-zero.
    for (int unsigned k = 0; k < DIGITS; k++) begin
      int unsigned i;
      i = DIGITS - 1 - k;
      seen_nz = seen_nz | (value[4*i +: 4] != 4'h0);
      dig_seg[i] = glyph(value[4*i +: 4]);
      dig_dp[i]  = ~dp_in[i];
      if (blank_lz && (i != 0) && !seen_nz) begin
        dig_seg[i] = '1;
      end
      if (blink_on && blink_mask[i]) begin
        dig_seg[i] = '1;
        dig_dp[i]  = 1'b1;
      end
    end
    if (SCAN_MODE != 0) begin
      seg_next[6:0] = dig_seg[scan_idx];
      dp_next[0]    = dig_dp[scan_idx];
      en_next       = ~(DIGITS'(1) << scan_idx);
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        seg_next[7*i +: 7] = dig_seg[i];
        dp_next[i]         = dig_dp[i];
      end
    end
  end

  // Value register, blink counter, scan timing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      value     <= '0;
      blink_cnt <= '0;
      scan_idx  <= '0;
      scan_div  <= '0;
      seg_out   <= '1;
      dp_out    <= '1;
      digit_en  <= (SCAN_MODE != 0) ? '1 : '0;
    end else begin
      if (wr_en) begin
        value <= wr_data;
      end
      blink_cnt <= blink_cnt + 1'b1;
      if (scan_div == DIVW'(SCAN_DIV - 1)) begin
        scan_div <= '0;
        scan_idx <= (scan_idx == IDXW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_div <= scan_div + 1'b1;
      end
      seg_out  <= seg_next;
      dp_out   <= dp_next;
      digit_en <= en_next;
    end
  end

endmodule
